// File: rtl/pc_ir_unit_if.sv
// Bus between the control unit and the PC/IR stage of the multicycle datapath.
// The control unit (or a testbench standing in for it) uses the master modport.
interface pc_ir_unit_if #(
  parameter int CNT_W = 32
);
  logic             PCWrite;
  logic [1:0]       Branch;
  logic             Zero;
  logic [1:0]       PCSrc;
  logic             IRWrite;
  logic [31:0]      ALUResult;
  logic [31:0]      ALUOut;
  logic [31:0]      MemRdData;
  logic [31:0]      PC;
  logic [31:0]      Instr;
  logic [31:0]      Data;
  logic             Fault;
  logic [31:0]      BadPC;
  logic [CNT_W-1:0] CycleCnt;
  logic [CNT_W-1:0] InstrCnt;

  modport master (
    output PCWrite, Branch, Zero, PCSrc, IRWrite, ALUResult, ALUOut, MemRdData,
    input  PC, Instr, Data, Fault, BadPC, CycleCnt, InstrCnt
  );

  modport slave (
    input  PCWrite, Branch, Zero, PCSrc, IRWrite, ALUResult, ALUOut, MemRdData,
    output PC, Instr, Data, Fault, BadPC, CycleCnt, InstrCnt
  );
endinterface

// File: rtl/pc_ir_unit.sv
// PC / instruction-register stage: holds PC, IR and MDR, resolves beq/bne
// enables, builds jump targets, traps misaligned PC updates and keeps cycle
// and decoded-instruction counters.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic           cclk,
  input logic           rstb,
  pc_ir_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    SRC_ALU_RESULT = 2'b00,
    SRC_ALU_OUT    = 2'b01,
    SRC_JUMP       = 2'b10,
    SRC_HOLD       = 2'b11
  } pc_src_e;

  logic [31:0]      pc;
  logic [31:0]      instr;
  logic [31:0]      data;
  logic             fault;
  logic [31:0]      bad_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             ir_write_q;

  logic             pc_en;
  logic [31:0]      next_pc;
  logic             pc_load;
  logic             misalign;
  logic             decode_entry;

  // Resolve the PC enable, select the next PC and classify the update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_en        = 1'b0;
    next_pc      = pc;
    pc_load      = 1'b0;
    misalign     = 1'b0;
    decode_entry = 1'b0;

    pc_en = bus.PCWrite | (bus.Branch[0] & bus.Zero) | (bus.Branch[1] & ~bus.Zero);

    unique case (pc_src_e'(bus.PCSrc))
      SRC_ALU_RESULT: next_pc = bus.ALUResult;
      SRC_ALU_OUT:    next_pc = bus.ALUOut;
      SRC_JUMP:       next_pc = {pc[31:28], instr[25:0], 2'b00};
      SRC_HOLD:       next_pc = pc;
      default:        next_pc = pc;
    endcase

    // Hold always yields the current (aligned) PC, so it can never trap.
    pc_load  = pc_en && !fault && (next_pc[1:0] == 2'b00);
    misalign = pc_en && !fault && (pc_src_e'(bus.PCSrc) != SRC_HOLD)
               && (next_pc[1:0] != 2'b00);

    // Falling edge of the (unfrozen) IR write marks entry to decode.
    decode_entry = ir_write_q && !bus.IRWrite && !fault;
  end

  // State registers; synchronous reset dominates every other input.
  always_ff @(posedge cclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rstb) begin
      pc         <= RESET_PC;
      instr      <= '0;
      data       <= '0;
      fault      <= 1'b0;
      bad_pc     <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      ir_write_q <= 1'b0;
    end else begin
      data      <= bus.MemRdData;
      cycle_cnt <= cycle_cnt + 1'b1;

      if (pc_load) begin
        pc <= next_pc;
      end

      if (misalign) begin
        fault  <= 1'b1;
        bad_pc <= next_pc;
      end

      if (bus.IRWrite && !fault) begin
        instr <= bus.MemRdData;
      end

      // A trapped stage ignores IRWrite, so the delay bit must not see it either.
      ir_write_q <= bus.IRWrite && !fault;

      if (decode_entry) begin
        instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end

  assign bus.PC       = pc;
  assign bus.Instr    = instr;
  assign bus.Data     = data;
  assign bus.Fault    = fault;
  assign bus.BadPC    = bad_pc;
  assign bus.CycleCnt = cycle_cnt;
  assign bus.InstrCnt = instr_cnt;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed-vector bench for pc_ir_unit: one default instance (RESET_PC=0,
// 32-bit counters) and one with RESET_PC=0x100 and 4-bit counters for wrap.
module tb_pc_ir_unit;

  logic cclk = 1'b0;
  logic rstb_a = 1'b1;
  logic rstb_b = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 cclk = ~cclk;

  pc_ir_unit_if #(.CNT_W(32)) bus_a ();
  pc_ir_unit_if #(.CNT_W(4))  bus_b ();

  pc_ir_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut_a (
    .cclk (cclk),
    .rstb (rstb_a),
    .bus  (bus_a.slave)
  );

  pc_ir_unit #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut_b (
    .cclk (cclk),
    .rstb (rstb_b),
    .bus  (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic drive_a(input logic pc_write, input logic [1:0] branch, input logic zero,
                         input logic [1:0] pc_src, input logic ir_write,
                         input logic [31:0] alu_result, input logic [31:0] alu_out,
                         input logic [31:0] mem_rd);
    bus_a.PCWrite   = pc_write;
    bus_a.Branch    = branch;
    bus_a.Zero      = zero;
    bus_a.PCSrc     = pc_src;
    bus_a.IRWrite   = ir_write;
    bus_a.ALUResult = alu_result;
    bus_a.ALUOut    = alu_out;
    bus_a.MemRdData = mem_rd;
  endtask

  initial begin
    bus_b.PCWrite   = 1'b0;
    bus_b.Branch    = 2'b00;
    bus_b.Zero      = 1'b0;
    bus_b.PCSrc     = 2'b00;
    bus_b.IRWrite   = 1'b0;
    bus_b.ALUResult = '0;
    bus_b.ALUOut    = '0;
    bus_b.MemRdData = '0;

    // Reset dominates: drive junk that would otherwise change state.
    drive_a(1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF);
    step();
    step();
    check("rst_pc",       bus_a.PC,       32'h0);
    check("rst_instr",    bus_a.Instr,    32'h0);
    check("rst_data",     bus_a.Data,     32'h0);
    check("rst_fault",    {31'b0, bus_a.Fault}, 32'h0);
    check("rst_badpc",    bus_a.BadPC,    32'h0);
    check("rst_cyclecnt", bus_a.CycleCnt, 32'h0);
    check("rst_instrcnt", bus_a.InstrCnt, 32'h0);

    // Prefetch: PC <- ALUResult = 4.
    rstb_a = 1'b0;
    drive_a(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 32'h0);
    step();                                             // cycle 1
    check("prefetch_pc", bus_a.PC,       32'h4);
    check("cycle_first", bus_a.CycleCnt, 32'h1);

    drive_a(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0, 32'h0);
    step();                                             // cycle 2
    check("pc_to_8", bus_a.PC, 32'h8);

    // beq taken.
    drive_a(1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000_0040, 32'h0);
    step();                                             // cycle 3
    check("beq_taken", bus_a.PC, 32'h40);

    drive_a(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0, 32'h0);
    step();                                             // cycle 4
    check("pc_back_8", bus_a.PC, 32'h8);

    // beq not taken.
    drive_a(1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0040, 32'h0);
    step();                                             // cycle 5
    check("beq_not_taken", bus_a.PC, 32'h8);

    // bne taken.
    drive_a(1'b0, 2'b10, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0040, 32'h0);
    step();                                             // cycle 6
    check("bne_taken", bus_a.PC, 32'h40);

    // bne not taken (Zero=1), different target to show PC truly holds.
    drive_a(1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000_0080, 32'h0);
    step();                                             // cycle 7
    check("bne_not_taken", bus_a.PC, 32'h40);

    // Set up jump: PC=0x1000_0004 and Instr=0x0800_0010 in the same edge.
    drive_a(1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 32'h1000_0004, 32'h0, 32'h0800_0010);
    step();                                             // cycle 8
    check("jump_setup_pc",    bus_a.PC,    32'h1000_0004);
    check("jump_setup_instr", bus_a.Instr, 32'h0800_0010);
    check("data_follows_mem", bus_a.Data,  32'h0800_0010);

    // Jump; IRWrite falls here so the decode counter ticks.
    drive_a(1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    step();                                             // cycle 9
    check("jump_pc",       bus_a.PC,       32'h1000_0040);
    check("instrcnt_jump", bus_a.InstrCnt, 32'h1);
    check("cycle_9",       bus_a.CycleCnt, 32'h9);

    // Two-cycle fetch; the second load wins.
    drive_a(1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'hAAAA_0001);
    step();                                             // cycle 10
    check("fetch1_instr", bus_a.Instr, 32'hAAAA_0001);
    drive_a(1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h2008_0005);
    step();                                             // cycle 11
    check("fetch2_instr",    bus_a.Instr,    32'h2008_0005);
    check("fetch2_instrcnt", bus_a.InstrCnt, 32'h1);
    drive_a(1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
    step();                                             // cycle 12
    check("decode_instr",    bus_a.Instr,    32'h2008_0005);
    check("decode_instrcnt", bus_a.InstrCnt, 32'h2);
    check("decode_data",     bus_a.Data,     32'h1234_5678);
    step();                                             // cycle 13
    check("instrcnt_once",   bus_a.InstrCnt, 32'h2);

    // Misaligned target traps.
    drive_a(1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0102, 32'h0);
    step();                                             // cycle 14
    check("trap_pc",    bus_a.PC,    32'h1000_0040);
    check("trap_fault", {31'b0, bus_a.Fault}, 32'h1);
    check("trap_badpc", bus_a.BadPC, 32'h0000_0102);

    // While faulted: PCWrite / IRWrite ignored, Data still updates.
    drive_a(1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D);
    step();                                             // cycle 15
    check("frozen_pc",    bus_a.PC,    32'h1000_0040);
    check("frozen_instr", bus_a.Instr, 32'h2008_0005);
    check("frozen_data",  bus_a.Data,  32'hCAFE_F00D);
    check("frozen_badpc", bus_a.BadPC, 32'h0000_0102);
    drive_a(1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
    step();                                             // cycle 16
    check("frozen_instrcnt", bus_a.InstrCnt, 32'h2);
    check("fault_cyclecnt",  bus_a.CycleCnt, 32'd16);
    check("fault_sticky",    {31'b0, bus_a.Fault}, 32'h1);

    // Only reset clears the trap.
    rstb_a = 1'b1;
    step();
    check("clr_fault", {31'b0, bus_a.Fault}, 32'h0);
    check("clr_pc",    bus_a.PC,    32'h0);
    check("clr_badpc", bus_a.BadPC, 32'h0);
    rstb_a = 1'b0;

    // Hold select with PCWrite: no change, no fault even if ALU values are odd.
    drive_a(1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 32'h0000_0003, 32'h0000_0001, 32'h0);
    step();
    check("hold_pc",    bus_a.PC, 32'h0);
    check("hold_fault", {31'b0, bus_a.Fault}, 32'h0);

    // Narrow-counter instance: reset PC and modulo-16 wrap.
    step();
    check("b_rst_pc",    bus_b.PC, 32'h0000_0100);
    check("b_rst_cycle", {28'b0, bus_b.CycleCnt}, 32'h0);
    bus_b.PCWrite   = 1'b1;
    bus_b.PCSrc     = 2'b11;
    bus_b.ALUResult = 32'h0000_0003;
    rstb_b = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step();
    end
    check("b_wrap_cycle", {28'b0, bus_b.CycleCnt}, 32'h1);
    check("b_hold_pc",    bus_b.PC, 32'h0000_0100);
    check("b_hold_fault", {31'b0, bus_b.Fault}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Program-counter and instruction-register stage of the multicycle MIPS datapath. It sits directly downstream of the control unit and consumes `PCWrite`, `Branch`, `PCSrc` and `IRWrite`. It holds `PC`, latches the fetched word into `Instr` (which feeds back to the control unit) and latches memory read data for write-back. It also resolves beq/bne branch enables, computes jump targets, traps misaligned PC updates, and keeps cycle and instruction counters.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; must be word-aligned.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `cclk` input 1: clock; all state updates on the rising edge.
- `rstb` input 1: reset, synchronous and active-high.
- `PCWrite` input 1: unconditional PC update request.
- `Branch` input 2: bit0 requests a beq update (taken when `Zero`=1); bit1 requests a bne update (taken when `Zero`=0).
- `Zero` input 1: ALU zero flag from the current cycle.
- `PCSrc` input 2: next-PC select. 00 = `ALUResult`, 01 = `ALUOut`, 10 = jump target, 11 = hold.
- `IRWrite` input 1: load `Instr` from `MemRdData`.
- `ALUResult` input 32: combinational ALU output.
- `ALUOut` input 32: registered ALU output.
- `MemRdData` input 32: memory read data.
- `PC` output 32: current program counter, registered.
- `Instr` output 32: instruction register.
- `Data` output 32: memory data register.
- `Fault` output 1: sticky misaligned-PC trap.
- `BadPC` output 32: rejected target captured at fault.
- `CycleCnt` output CNT_W: cycles since reset.
- `InstrCnt` output CNT_W: instructions decoded since reset.

## Operation
- `PCEn` = `PCWrite` | (`Branch[0]` & `Zero`) | (`Branch[1]` & ~`Zero`).
- The two `Branch` bits and `PCWrite` may be asserted together; they are ORed.
- Next PC:
  - `PCSrc`=00: `ALUResult`.
  - `PCSrc`=01: `ALUOut`.
  - `PCSrc`=10: {`PC[31:28]`, `Instr[25:0]`, 2'b00}.
  - `PCSrc`=11: `PC` (no change, no fault check).
- PC update: when `PCEn`=1, `Fault`=0 and next PC[1:0]=00, `PC` loads next PC.
- Misalignment: when `PCEn`=1, `Fault`=0, `PCSrc`≠11 and next PC[1:0]≠00:
  - `PC` holds.
  - `Fault` sets.
  - `BadPC` captures next PC.
- While `Fault`=1:
  - `PCEn` and `IRWrite` are ignored; `PC` and `Instr` are frozen.
  - `Data` keeps updating.
  - `CycleCnt` keeps counting; `InstrCnt` freezes.
  - Only `rstb` clears `Fault`.
- `Instr` loads `MemRdData` on every cycle with `IRWrite`=1 and `Fault`=0. The control unit holds `IRWrite` high for two consecutive fetch cycles; the second load wins.
- `Data` loads `MemRdData` every cycle, unconditionally.
- `InstrCnt` increments by 1 on the cycle after an `IRWrite` 1→0 transition (entry to decode). This needs a registered `IRWrite` delay bit.
- Both counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values, held while `rstb`=1:
  - `PC`=`RESET_PC`.
  - `Instr`=0 (decodes as an R-type sll nop).
  - `Data`=0.
  - `Fault`=0.
  - `BadPC`=0.
  - `CycleCnt`=0.
  - `InstrCnt`=0.
  - `IRWrite` delay bit = 0.
- Reset dominates every other input in the same cycle; a reset mid-instruction discards the in-flight update.
- `PC` latency: an enable sampled at edge N is visible at `PC` after edge N. The jump target uses the `PC`/`Instr` values from before that edge.
- `Instr` and `Data` have one-cycle latency from `MemRdData`.
- `CycleCnt`: the first edge after reset release gives 1.
- `InstrCnt`: for `IRWrite` high on cycles k and k+1 and low on k+2, `InstrCnt` increments at the edge ending cycle k+2 and is visible on k+3.
- `Fault` and `BadPC` are visible the cycle after the offending edge.

## Test plan
- **Reset / prefetch:** pulse `rstb` high 2 cycles with `RESET_PC`=0. Then drive `PCWrite`=1, `PCSrc`=00, `ALUResult`=4 → `PC`=4 next cycle; all other outputs were 0 during reset.
- **Branch resolve:** `PC`=8, `PCSrc`=01, `ALUOut`=0x40.
  - `Branch`=01, `Zero`=1 → `PC`=0x40.
  - `Branch`=01, `Zero`=0 → `PC` stays 8.
  - `Branch`=10, `Zero`=0 → `PC`=0x40.
- **Jump:** `PC`=0x1000_0004, `Instr`=0x0800_0010, `PCSrc`=10, `PCWrite`=1 → `PC`=0x1000_0040.
- **Instruction fetch and count:** `MemRdData`=0x2008_0005 with `IRWrite` high 2 cycles then low → `Instr`=0x2008_0005; `InstrCnt` goes 0→1 exactly once.
- **Misalign trap:** `PCWrite`=1, `PCSrc`=01, `ALUOut`=0x0000_0102 →
  - `PC` unchanged, `Fault`=1, `BadPC`=0x102.
  - Subsequent `PCWrite`/`IRWrite` are ignored.
  - `rstb` clears `Fault`.
- **Counter wrap / hold:** with `CNT_W`=4, run 17 cycles → `CycleCnt`=1. `PCSrc`=11 with `PCWrite`=1 → `PC` unchanged and `Fault` stays 0.
